// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the MIPS datapath and the multiply/divide unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [5:0]       OpCode;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic             Stall;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic [WIDTH-1:0] MDResult;

    modport master (
        output Start, OpCode, Funct, A, B,
        input  Busy, Done, Stall, HI, LO, MDResult
    );

    modport slave (
        input  Start, OpCode, Funct, A, B,
        output Busy, Done, Stall, HI, LO, MDResult
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide on magnitudes,
// with a final sign-fix cycle.
//
// state  | meaning
// S_IDLE | waiting; accepts mult/div, applies mthi/mtlo, serves mfhi/mflo
// S_RUN  | one multiply or divide step per cycle, Cnt 0..WIDTH-1
// S_FIX  | apply result signs and write HI/LO, pulse Done
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic is_r, is_mul, is_div, is_signed;
    logic is_mfhi, is_mflo, is_mthi, is_mtlo, is_md;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_r      = (bus.OpCode == 6'h00);
    assign is_mul    = is_r && (bus.Funct == 6'h18 || bus.Funct == 6'h19);
    assign is_div    = is_r && (bus.Funct == 6'h1a || bus.Funct == 6'h1b);
    assign is_signed = ~bus.Funct[0];
    assign is_mfhi   = is_r && (bus.Funct == 6'h10);
    assign is_mthi   = is_r && (bus.Funct == 6'h11);
    assign is_mflo   = is_r && (bus.Funct == 6'h12);
    assign is_mtlo   = is_r && (bus.Funct == 6'h13);
    assign is_md     = is_mul | is_div | is_mfhi | is_mthi | is_mflo | is_mtlo;

    assign a_neg = is_signed & bus.A[WIDTH-1];
    assign b_neg = is_signed & bus.B[WIDTH-1];
    assign a_mag = a_neg ? -bus.A : bus.A;
    assign b_mag = b_neg ? -bus.B : bus.B;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Datapath for one iteration step and for the final sign fix.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {rem, acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // When div_ge holds the difference fits in WIDTH bits, so modular subtraction is exact.
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -rem : rem;
    end

    // Sequencer, iteration registers and HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            a_raw    <= '0;
            acc      <= '0;
            rem      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.Start && (is_mul || is_div)) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        op_div   <= is_div;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= is_div && (bus.B == '0);
                        a_raw    <= bus.A;
                        rem      <= '0;
                        // Divide walks the dividend through the low half; multiply
                        // keeps the multiplier there and accumulates in the high half.
                        opnd     <= is_div ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
                    end else if (bus.Start && is_mthi) begin
                        hi <= bus.A;
                    end else if (bus.Start && is_mtlo) begin
                        lo <= bus.A;
                    end
                end
                S_RUN: begin
                    if (op_div) begin
                        rem              <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!op_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (div_zero) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.Busy     = busy;
    assign bus.Done     = done;
    assign bus.HI       = hi;
    assign bus.LO       = lo;
    assign bus.Stall    = busy & bus.Start & is_md;
    assign bus.MDResult = is_mfhi ? hi : (is_mflo ? lo : '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors, timing corner sequences and a random
// mix checked against an arithmetic reference, on a 32-bit and an 8-bit instance.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) b32 ();
    muldiv_unit_if #(.WIDTH(8))  b8 ();

    muldiv_unit #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));
    muldiv_unit #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8.slave));

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on w-bit values.
    function automatic void model(input int w, input logic [5:0] f, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] hi, output logic [63:0] lo);
        logic [63:0] mask;
        logic [63:0] p;
        longint sa, sb;
        bit sgn;
        mask = (64'd1 << w) - 64'd1;
        sgn  = (f == 6'h18 || f == 6'h1a);
        sa   = longint'(a & mask);
        sb   = longint'(b & mask);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        if (f == 6'h18 || f == 6'h19) begin
            p  = 64'(sa * sb);
            hi = (p >> w) & mask;
            lo = p & mask;
        end else if ((b & mask) == 64'd0) begin
            lo = mask;
            hi = a & mask;
        end else begin
            lo = 64'(sa / sb) & mask;
            hi = 64'(sa % sb) & mask;
        end
    endfunction

    task automatic idle32();
        b32.Start = 1'b0; b32.OpCode = 6'h00; b32.Funct = 6'h00; b32.A = '0; b32.B = '0;
    endtask

    // Issue one iterative op; returns in the Done cycle.
    task automatic run_op32(input string name, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        b32.Start = 1'b1; b32.OpCode = 6'h00; b32.Funct = f; b32.A = a; b32.B = b;
        tick();
        idle32();
        cyc = 0;
        while (b32.Busy && cyc < 100) begin
            cyc++;
            tick();
        end
        chk({name, " busy cycles"}, 64'(cyc), 64'd33);
        chk({name, " done"}, 64'(b32.Done), 64'd1);
        chk({name, " hi"}, 64'(b32.HI), 64'(ehi));
        chk({name, " lo"}, 64'(b32.LO), 64'(elo));
    endtask

    task automatic run_op8(input string name, input logic [5:0] f, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] ehi, input logic [7:0] elo);
        int cyc;
        b8.Start = 1'b1; b8.OpCode = 6'h00; b8.Funct = f; b8.A = a; b8.B = b;
        tick();
        b8.Start = 1'b0; b8.Funct = 6'h00;
        cyc = 0;
        while (b8.Busy && cyc < 100) begin
            cyc++;
            tick();
        end
        chk({name, " busy cycles"}, 64'(cyc), 64'd9);
        chk({name, " done"}, 64'(b8.Done), 64'd1);
        chk({name, " hi"}, 64'(b8.HI), 64'(ehi));
        chk({name, " lo"}, 64'(b8.LO), 64'(elo));
    endtask

    initial begin
        logic [63:0] mh, ml;
        logic [5:0]  ops[4];
        logic [5:0]  f;
        logic [31:0] ra, rb;
        logic [7:0]  sa8, sb8;

        ops[0] = 6'h18; ops[1] = 6'h19; ops[2] = 6'h1a; ops[3] = 6'h1b;

        tbl[0] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[1] = '{6'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[2] = '{6'h1a, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{6'h1b, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        tbl[4] = '{6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[5] = '{6'h1a, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        tbl[6] = '{6'h1b, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        tbl[7] = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        idle32();
        b8.Start = 1'b0; b8.OpCode = 6'h00; b8.Funct = 6'h00; b8.A = '0; b8.B = '0;
        reset = 1'b1;
        repeat (3) tick();

        // Reset state, with an mfhi presented to see MDResult.
        b32.Start = 1'b1; b32.Funct = 6'h10;
        #1;
        chk("reset busy", 64'(b32.Busy), 64'd0);
        chk("reset done", 64'(b32.Done), 64'd0);
        chk("reset hi", 64'(b32.HI), 64'd0);
        chk("reset lo", 64'(b32.LO), 64'd0);
        chk("reset mdresult", 64'(b32.MDResult), 64'd0);
        chk("reset stall", 64'(b32.Stall), 64'd0);
        idle32();
        reset = 1'b0;
        tick();

        // mthi/mtlo apply at the next edge without Done; mfhi/mflo read same cycle.
        b32.Start = 1'b1; b32.Funct = 6'h11; b32.A = 32'hDEADBEEF;
        tick();
        chk("mthi hi", 64'(b32.HI), 64'hDEADBEEF);
        chk("mthi no done", 64'(b32.Done), 64'd0);
        b32.Funct = 6'h13; b32.A = 32'h0BADF00D;
        tick();
        chk("mtlo lo", 64'(b32.LO), 64'h0BADF00D);
        b32.Funct = 6'h10;
        #1;
        chk("mfhi read", 64'(b32.MDResult), 64'hDEADBEEF);
        b32.Funct = 6'h12;
        #1;
        chk("mflo read", 64'(b32.MDResult), 64'h0BADF00D);
        b32.Funct = 6'h20;
        #1;
        chk("add mdresult zero", 64'(b32.MDResult), 64'd0);
        // Right funct but non-zero opcode: not decoded.
        b32.OpCode = 6'h01; b32.Funct = 6'h18; b32.A = 32'd3; b32.B = 32'd4;
        tick();
        chk("bad opcode ignored", 64'(b32.Busy), 64'd0);
        idle32();
        tick();

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            run_op32($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);
            tick();
            chk($sformatf("vec%0d done drop", i), 64'(b32.Done), 64'd0);
        end

        // mflo issued at E5 of multu stalls until Done; mthi during Busy is dropped.
        b32.Start = 1'b1; b32.Funct = 6'h19; b32.A = 32'hFFFFFFFF; b32.B = 32'hFFFFFFFF;
        tick();
        idle32();
        repeat (4) tick();
        for (int c = 0; c < 40; c++) begin
            if (!b32.Busy) break;
            b32.Start = 1'b1;
            if (c == 3) begin
                b32.Funct = 6'h11; b32.A = 32'h11111111;
                #1;
                chk("mthi busy stall", 64'(b32.Stall), 64'd1);
            end else if (c == 4) begin
                b32.OpCode = 6'h08; b32.Funct = 6'h12;
                #1;
                chk("non-md no stall", 64'(b32.Stall), 64'd0);
                b32.OpCode = 6'h00;
            end else begin
                b32.Funct = 6'h12;
                #1;
                if (b32.Stall !== 1'b1) chk("mflo stall", 64'(b32.Stall), 64'd1);
            end
            tick();
        end
        b32.Start = 1'b1; b32.Funct = 6'h12;
        #1;
        chk("stall done cycle done", 64'(b32.Done), 64'd1);
        chk("stall released", 64'(b32.Stall), 64'd0);
        chk("mflo new lo", 64'(b32.MDResult), 64'h00000001);
        chk("mthi busy dropped", 64'(b32.HI), 64'hFFFFFFFE);
        tick();
        idle32();

        // Reset at E10 of a div aborts it.
        b32.Start = 1'b1; b32.Funct = 6'h1a; b32.A = 32'hFFFFFFF9; b32.B = 32'd2;
        tick();
        idle32();
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", 64'(b32.Busy), 64'd0);
        chk("abort done", 64'(b32.Done), 64'd0);
        chk("abort hi", 64'(b32.HI), 64'd0);
        chk("abort lo", 64'(b32.LO), 64'd0);
        b32.Start = 1'b1; b32.Funct = 6'h13; b32.A = 32'hA5A5A5A5;
        tick();
        idle32();
        chk("mtlo after abort", 64'(b32.LO), 64'hA5A5A5A5);
        tick();
        repeat (5) tick();
        chk("no late done", 64'(b32.Done), 64'd0);
        chk("no late hi", 64'(b32.HI), 64'd0);

        // Random back-to-back ops: each new op is accepted in the previous Done cycle.
        for (int i = 0; i < 40; i++) begin
            f  = ops[$urandom_range(0, 3)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = $urandom_range(1, 20);
                default: ;
            endcase
            model(32, f, 64'(ra), 64'(rb), mh, ml);
            run_op32($sformatf("rnd%0d f=%h a=%h b=%h", i, f, ra, rb), f, ra, rb, mh[31:0], ml[31:0]);
        end
        tick();
        chk("rnd done drop", 64'(b32.Done), 64'd0);

        // Narrow instance: MIN by -1 and a random spread.
        run_op8("w8 mult min", 6'h18, 8'h80, 8'hFF, 8'h00, 8'h80);
        tick();
        run_op8("w8 div min", 6'h1a, 8'h80, 8'hFF, 8'h00, 8'h80);
        tick();
        for (int i = 0; i < 30; i++) begin
            f   = ops[$urandom_range(0, 3)];
            sa8 = 8'($urandom);
            sb8 = 8'($urandom);
            if (i % 7 == 0) sb8 = 8'h00;
            model(8, f, 64'(sa8), 64'(sb8), mh, ml);
            run_op8($sformatf("w8 rnd%0d f=%h a=%h b=%h", i, f, sa8, sb8), f, sa8, sb8, mh[7:0], ml[7:0]);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
